// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounces a raw button into a level plus press/release/auto-repeat pulses
//   CLK, RST       : clock, asynchronous active-high reset
//   btn_in         : raw asynchronous button level (1 = pressed)
//   rpt_en         : auto-repeat enable while held
//   btn_level      : debounced level
//   press_pulse    : one cycle on accepted press and each auto-repeat
//   release_pulse  : one cycle on accepted release
module btn_pulse_gen #(
  parameter int unsigned DB_CYCLES  = 500000,
  parameter int unsigned RPT_DELAY  = 25000000,
  parameter int unsigned RPT_PERIOD = 5000000,
  parameter int unsigned CNT_W      = 25
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_in,
  input  logic rpt_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rpt_ph_q;
  logic [1:0]       sync_q;
  logic             level_q, press_q, rel_q;
  logic             btn_s;
  logic [CNT_W-1:0] rpt_last;
  assign btn_s         = sync_q[1];
  assign rpt_last      = rpt_ph_q ? PER_LAST : DLY_LAST;
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rpt_ph_q <= 1'b0;
      sync_q   <= 2'b00;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      case (state_q)
        IDLE: if (btn_s) begin
          state_q <= DB_PRESS;
          cnt_q   <= '0;
        end
        DB_PRESS: if (!btn_s) state_q <= IDLE;
        else if (cnt_q == DB_LAST) begin
          state_q  <= HELD;
          cnt_q    <= '0;
          rpt_ph_q <= 1'b0;
          level_q  <= 1'b1;
          press_q  <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        HELD: if (!btn_s) begin
          state_q <= DB_RELEASE;
          cnt_q   <= '0;
        end else if (!rpt_en) begin
          cnt_q    <= '0;
          rpt_ph_q <= 1'b0;
        end else if (cnt_q == rpt_last) begin
          press_q  <= 1'b1;
          cnt_q    <= '0;
          rpt_ph_q <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        DB_RELEASE: if (btn_s) begin
          // a bounce back to pressed restarts repeat timing from the initial delay
          state_q  <= HELD;
          cnt_q    <= '0;
          rpt_ph_q <= 1'b0;
        end else if (cnt_q == DB_LAST) begin
          state_q <= IDLE;
          level_q <= 1'b0;
          rel_q   <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          rpt_ph_q <= 1'b0;
          level_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: scoreboard bench for btn_pulse_gen against a run-length reference model
module tb_btn_pulse_gen;
  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  logic CLK, RST, btn_in, rpt_en;
  logic btn_level, press_pulse, release_pulse;
  btn_pulse_gen #(.DB_CYCLES(DB), .RPT_DELAY(DLY), .RPT_PERIOD(PER), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .btn_in(btn_in), .rpt_en(rpt_en),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );
  typedef struct { int cyc; bit rel; } ev_t;
  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0, cyc = 0;
  bit  lvl_m = 0, ph_m = 0, h1 = 0, h2 = 0;
  int  run = 0, tmr = 0;
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  // Model: a level change is accepted once the synchronized input has disagreed with the
  // current level for DB+1 consecutive edges; repeats count uninterrupted held edges.
  task automatic step();
    bit s;
    cyc++;
    if (RST) begin
      lvl_m = 0; ph_m = 0; h1 = 0; h2 = 0; run = 0; tmr = 0;
    end else begin
      s  = h2;
      h2 = h1;
      h1 = btn_in;
      if (s != lvl_m) begin
        run++;
        if (run == DB + 1) begin
          exp_q.push_back('{cyc, !s});
          lvl_m = s; run = 0; tmr = 0; ph_m = 0;
        end
      end else begin
        if (lvl_m) begin
          if (run != 0 || !rpt_en) begin
            tmr = 0; ph_m = 0;
          end else begin
            tmr++;
            if (tmr == (ph_m ? PER : DLY)) begin
              exp_q.push_back('{cyc, 1'b0});
              tmr = 0; ph_m = 1;
            end
          end
        end
        run = 0;
      end
    end
  endtask
  task automatic drive(input bit b, input bit r, input bit rs, input int n);
    RST = rs;
    for (int i = 0; i < n; i++) begin
      btn_in = b;
      rpt_en = r;
      @(posedge CLK);
      step();
      @(negedge CLK);
    end
  endtask
  initial begin : monitor
    ev_t e;
    forever begin
      @(posedge CLK);
      #1;
      n_cmp++;
      if (btn_level !== lvl_m) begin
        n_bad++;
        $display("FAIL level cyc=%0d got=%b want=%b", cyc, btn_level, lvl_m);
      end
      if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL both_pulses cyc=%0d got press=1 release=1 want at most one", cyc);
      end else if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b want none", cyc, press_pulse, release_pulse);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.rel != release_pulse) begin
            n_bad++;
            $display("FAIL pulse cyc=%0d got rel=%b want rel=%b at cyc=%0d", cyc, release_pulse, e.rel, e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        n_cmp++; n_bad++;
        e = exp_q.pop_front();
        $display("FAIL missing_pulse cyc=%0d got none want rel=%b at cyc=%0d", cyc, e.rel, e.cyc);
      end
    end
  end
  initial begin : stim
    RST = 1; btn_in = 0; rpt_en = 0;
    @(negedge CLK);
    drive(0, 0, 1, 3);
    drive(0, 0, 0, 4);
    // clean press, no repeat, then release
    drive(1, 0, 0, 30);
    drive(0, 0, 0, 12);
    // bouncing press
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 2);
      drive(0, 0, 0, 1);
      drive(1, 0, 0, 2);
      drive(0, 0, 0, 1);
    end
    drive(1, 0, 0, 12);
    // bouncing release
    drive(0, 0, 0, 2);
    drive(1, 0, 0, 2);
    drive(0, 0, 0, 2);
    drive(1, 0, 0, 2);
    drive(0, 0, 0, 14);
    // auto-repeat
    drive(1, 1, 0, 37);
    drive(0, 1, 0, 12);
    // repeat enable dropped mid-wait
    drive(1, 1, 0, 14);
    drive(1, 0, 0, 3);
    drive(1, 1, 0, 20);
    drive(0, 0, 0, 12);
    // reset mid-debounce with the button still held
    drive(1, 0, 0, 4);
    drive(1, 0, 1, 2);
    drive(1, 0, 0, 15);
    drive(0, 0, 0, 12);
    // single-cycle glitch
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 10);
    // randomized segments
    for (int k = 0; k < 250; k++) begin
      bit b, r, rs;
      b  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 5) != 0);
      rs = ($urandom_range(0, 40) == 0);
      drive(b, r, rs, rs ? 2 : int'($urandom_range(1, 25)));
    end
    drive(0, 0, 0, 20);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got %0d pending pulses want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btn_pulse_gen.md
# btn_pulse_gen

Debounced push-button front end that turns a raw, bouncing, asynchronous button level into clean single-cycle pulses. It sits directly upstream of the pulse-delay counter: `press_pulse` drives that stage's `start_count` input. It also provides a debounced level, a release pulse and optional auto-repeat while the button is held. All outputs are registered and synchronous to `CLK`.

## Interface
- `DB_CYCLES`, default 500000: stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- `RPT_DELAY`, default 25000000: held cycles before the first auto-repeat pulse; minimum 2.
- `RPT_PERIOD`, default 5000000: cycles between subsequent auto-repeat pulses; minimum 2.
- `CNT_W`, default 25: counter width; must satisfy 2^CNT_W > max(DB_CYCLES, RPT_DELAY, RPT_PERIOD).
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  asynchronous, active-high reset.
- `btn_in`  in  1  raw button level, asynchronous, 1 = pressed.
- `rpt_en`  in  1  synchronous auto-repeat enable.
- `btn_level`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle pulse on accepted press and on each auto-repeat.
- `release_pulse`  out  1  one-cycle pulse on accepted release.

## Operation
- Synchronizer: two flops on `btn_in`, both reset to 0. `btn_s` is the second flop. The FSM sees only `btn_s`.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE. One shared counter `cnt` (CNT_W bits) and one phase flag `rpt_ph` (0 = waiting RPT_DELAY, 1 = waiting RPT_PERIOD).
- IDLE: when `btn_s`=1, go to DB_PRESS and set `cnt`=0.
- DB_PRESS:
  - `btn_s`=0: return to IDLE, no pulse (glitch rejected).
  - Otherwise increment `cnt`.
  - When `cnt`==DB_CYCLES-1 and `btn_s`=1: go to HELD, set `cnt`=0, `rpt_ph`=0, `btn_level`=1, and pulse `press_pulse` for one cycle.
- HELD:
  - `btn_s`=0: go to DB_RELEASE and set `cnt`=0.
  - `rpt_en`=0: hold `cnt`=0 and `rpt_ph`=0.
  - `rpt_en`=1: increment `cnt`.
  - When `cnt` reaches the phase limit minus 1 (RPT_DELAY-1 if `rpt_ph`=0, RPT_PERIOD-1 if `rpt_ph`=1): pulse `press_pulse`, set `cnt`=0, `rpt_ph`=1.
- DB_RELEASE:
  - `btn_s`=1: return to HELD, set `cnt`=0 and `rpt_ph`=0 (repeat timing restarts). No pulse; `btn_level` stays 1.
  - Otherwise increment `cnt`.
  - When `cnt`==DB_CYCLES-1: go to IDLE, set `btn_level`=0, and pulse `release_pulse`.
- No auto-repeat pulses are produced in DB_RELEASE.
- `press_pulse` and `release_pulse` are never high in the same cycle.
- No illegal states: any unused encoding recovers to IDLE with all outputs 0.
- Counter arithmetic is unsigned; `cnt` never exceeds its limit, so it never wraps.
- `press_pulse` is emitted regardless of whether the downstream delay stage is busy. Dropping pulses during a count is that stage's behaviour, not this block's.

## Timing
- Reset (async assert; release synchronous to `CLK`):
  - State IDLE; `cnt`, `rpt_ph` and both sync flops = 0.
  - `btn_level`=0, `press_pulse`=0, `release_pulse`=0.
- Reset mid-operation aborts any debounce or repeat in progress and emits no pulse.
- A button still held when `RST` falls is treated as a new press and produces `press_pulse` after the full debounce.
- Press latency (edge 0 = first `CLK` edge sampling `btn_in`=1, with the button stable afterwards):
  - `btn_s`=1 after edge 1; DB_PRESS entered at edge 2.
  - `press_pulse` and `btn_level` rise at edge DB_CYCLES+2; `press_pulse` falls one edge later.
- Release latency: symmetric. `release_pulse` rises and `btn_level` falls at edge DB_CYCLES+2 after the first `btn_in`=0 sample.
- Auto-repeat, with `rpt_en` held at 1:
  - First repeat pulse comes RPT_DELAY edges after the initial `press_pulse` edge.
  - Further pulses follow every RPT_PERIOD edges.
- `rpt_en` falling mid-wait resets the repeat phase. When it rises again, timing restarts from RPT_DELAY.
- Output pulse width is always exactly one `CLK` cycle.

## Test plan
Parameters for all scenarios: DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, CNT_W=8.
- Clean press: `btn_in` 0→1 sampled at edge 0, held 30 cycles, `rpt_en`=0 -> `press_pulse` high only in the cycle after edge 6; `btn_level`=1 from edge 6; no further pulses.
- Bounce: `btn_in` high 2 cycles, low 1, high 2, low, repeated 5 times, then stable high -> no pulse during bouncing; exactly one `press_pulse`, 6 edges after the final stable rise.
- Release with bounce: from HELD, `btn_in` toggles 1-0-1-0 at 2-cycle intervals, then stays 0 -> one `release_pulse` 6 edges after the final fall; `btn_level` 1→0 on that edge; no `press_pulse`.
- Auto-repeat: `rpt_en`=1, press held 30 cycles after the first `press_pulse` at edge 6 -> further `press_pulse` at edges 16, 19, 22, 25, 28, 31, 34.
- Reset mid-debounce: press, assert `RST` at edge 4 for 2 cycles with `btn_in` kept 1 -> all outputs 0 during reset; `press_pulse` appears 6 edges after the first post-reset sampling edge.
- Glitch rejection: one single-cycle `btn_in` high, then low -> no outputs change.
